ex_div: RTL
===========

// Module: ex_div
// PURPOSE
//   Multi-cycle RV32M divider in the EX stage (DIV/DIVU/REM/REMU). It requests a pipeline
//   stall by driving stallreq_o into ctrl's stallreq_id_ex_i while it iterates, which
//   freezes pc_reg, if_id and id_ex. enter_i (trap entry, same signal ctrl receives)
//   aborts an in-flight division. Radix-2 restoring algorithm, one quotient bit per cycle.
// PARAMETERS
//   XLEN      32   operand/result width; iteration count = XLEN
// PORTS
//   clk           in   1     core clock, rising edge
//   rst_n         in   1     asynchronous active-low reset
//   start_i       in   1     EX holds a divide op; held high by the stalled id_ex register
//   op_i          in   2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i    in   XLEN  rs1 value
//   divisor_i     in   XLEN  rs2 value
//   enter_i       in   1     trap entry; cancels any operation
//   stallreq_o    out  1     stall request to ctrl
//   result_o      out  XLEN  quotient or remainder, valid when valid_o
//   valid_o       out  1     one-cycle strobe: result_o is final
// BEHAVIOUR
//   Reset: state=IDLE, counter=0, stallreq_o=0, valid_o=0, result_o=0.
//   FSM states: IDLE, BUSY, DONE.
//   IDLE:
//     - start_i & ~enter_i: latch op, operand signs, |dividend|, |divisor|. Absolute values
//       apply only to signed ops (00/10).
//     - divisor==0 or signed overflow: go to DONE with the special result.
//     - otherwise: go to BUSY with counter=0.
//   BUSY:
//     - per cycle: {rem,quo} <<= 1; if rem >= divisor, subtract and set quo[0]; counter++.
//     - counter==XLEN-1 -> DONE.
//   DONE:
//     - valid_o=1 and result_o registered for exactly this cycle.
//     - next state IDLE. start_i is ignored here: it is the same instruction,
//       released this cycle.
//   stallreq_o is combinational: (IDLE & start_i & ~enter_i) | BUSY.
//     - low in DONE, so the pipeline advances exactly on the valid_o cycle.
//   Latency, normal operation:
//     - stallreq_o high for XLEN+1 cycles (1 IDLE cycle + XLEN BUSY cycles).
//     - result on the next cycle.
//   Latency, special cases: stallreq_o high for 1 cycle, result on the next cycle.
//   Sign fixup, applied on entry to DONE:
//     - quotient negated if sign(a)^sign(b), signed ops only.
//     - remainder takes sign(a), signed ops only.
//   Special cases (RISC-V spec):
//     - divisor 0: quotient = all ones; remainder = dividend.
//     - DIV/REM 0x80000000 / -1: quotient = 0x80000000; remainder = 0.
//   enter_i, any state:
//     - next state IDLE and valid_o=0 next cycle.
//     - stallreq_o forced low in the same cycle (combinational gate).
//     - datapath contents don't-care.
//   Asynchronous reset mid-operation: immediate return to reset values. No result emitted.
//   Back-to-back divides: a new start_i is accepted in IDLE on the cycle after DONE.
//   All arithmetic is unsigned XLEN+1 bits internally. Compare/subtract uses the
//   (XLEN+1)-bit partial remainder.
// TESTING
//   1. DIVU 100/7:
//      - stallreq_o high 33 cycles.
//      - next cycle valid_o=1, result_o=14.
//      - REMU with the same operands -> 2.
//   2. DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3).
//      - REM with the same operands -> 0xFFFFFFFF(-1).
//      - DIV 7/-2 -> -3; REM 7/-2 -> 1.
//   3. DIVU 5/0:
//      - stallreq_o high 1 cycle, then result 0xFFFFFFFF.
//      - REMU 5/0 -> 5.
//      - DIV 5/0 -> 0xFFFFFFFF.
//   4. DIV 0x80000000/0xFFFFFFFF: 1-cycle stall, result 0x80000000.
//      - REM with the same operands -> 0.
//   5. Start DIVU; assert enter_i on the 10th BUSY cycle:
//      - stallreq_o low in the same cycle.
//      - state IDLE next cycle; valid_o never pulses.
//      - a following DIVU 9/3 -> 3.
//   6. Drop rst_n during BUSY:
//      - outputs zero asynchronously.
//      - after release, two back-to-back DIVU ops (1000/10, then 81/9) -> 100, then 9.
//      - exactly one valid_o pulse each.

Source files
------------

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
//  Module   : ex_div
//  Brief    : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
//             Radix-2 restoring division, one quotient bit per cycle. Holds
//             the pipeline through stallreq_o while iterating; trap entry
//             (enter_i) cancels any operation in flight.
//  Revision : 1.0  initial release
// ============================================================================
module ex_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            enter_i,
    output logic            stallreq_o,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [CW-1:0]   C_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] C_SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_ONES     = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [XLEN-1:0]   rem_q,     rem_d;      // partial remainder (always < divisor)
    logic [XLEN-1:0]   quo_q,     quo_d;      // dividend shifting out / quotient shifting in
    logic [XLEN-1:0]   div_q,     div_d;      // |divisor|
    logic              op_rem_q,  op_rem_d;   // 1: REM/REMU, 0: DIV/DIVU
    logic              neg_quo_q, neg_quo_d;  // quotient needs negation at the end
    logic              neg_rem_q, neg_rem_d;  // remainder needs negation at the end
    logic [XLEN-1:0]   result_q,  result_d;

    // ------------------------------------------------------------------
    // Operand decode for a newly accepted operation
    // ------------------------------------------------------------------
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    assign w_signed   = ~op_i[0];
    assign w_a_neg    = w_signed & dividend_i[XLEN-1];
    assign w_b_neg    = w_signed & divisor_i[XLEN-1];
    assign w_a_abs    = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_abs    = w_b_neg ? -divisor_i  : divisor_i;
    assign w_div_zero = (divisor_i == '0);
    assign w_ovf      = w_signed & (dividend_i == C_SMIN) & (divisor_i == C_ONES);
    assign w_special  = w_div_zero | w_ovf;

    // Divide-by-zero: quotient all ones, remainder is the dividend.
    // Signed overflow: quotient is the dividend (most negative), remainder 0.
    assign w_special_res = op_i[1] ? (w_div_zero ? dividend_i : '0)
                                   : (w_div_zero ? C_ONES     : dividend_i);

    // ------------------------------------------------------------------
    // One restoring iteration on the (XLEN+1)-bit shifted remainder
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [XLEN-1:0]   w_rem_step;
    logic [XLEN-1:0]   w_quo_step;
    logic [XLEN-1:0]   w_fix_quo;
    logic [XLEN-1:0]   w_fix_rem;

    assign w_shift    = {rem_q, quo_q[XLEN-1]};
    assign w_ge       = (w_shift >= {1'b0, div_q});
    // Subtraction only taken when w_shift >= div_q, so the result fits XLEN bits.
    assign w_sub      = w_shift[XLEN-1:0] - div_q;
    assign w_rem_step = w_ge ? w_sub : w_shift[XLEN-1:0];
    assign w_quo_step = {quo_q[XLEN-2:0], w_ge};
    assign w_fix_quo  = neg_quo_q ? -w_quo_step : w_quo_step;
    assign w_fix_rem  = neg_rem_q ? -w_rem_step : w_rem_step;

    // Next-state and datapath update for IDLE/BUSY/DONE, trap entry overrides
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        op_rem_d  = op_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_rem_d  = op_i[1];
                    neg_quo_d = w_a_neg ^ w_b_neg;
                    neg_rem_d = w_a_neg;
                    rem_d     = '0;
                    quo_d     = w_a_abs;
                    div_d     = w_b_abs;
                    cnt_d     = '0;
                    if (w_special) begin
                        state_d  = S_DONE;
                        result_d = w_special_res;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                rem_d = w_rem_step;
                quo_d = w_quo_step;
                cnt_d = cnt_q + C_CNT_ONE;
                if (cnt_q == C_CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = op_rem_q ? w_fix_rem : w_fix_quo;
                end
            end
            S_DONE: begin
                // start_i here belongs to the instruction being released
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_i) begin
            state_d  = S_IDLE;
            result_d = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            op_rem_q  <= op_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // Stall is low in DONE so the pipeline advances on the valid cycle
    assign stallreq_o = (((state_q == S_IDLE) & start_i) | (state_q == S_BUSY)) & ~enter_i;
    assign valid_o    = (state_q == S_DONE);
    assign result_o   = result_q;

endmodule
`default_nettype wire
